// File: rtl/rtc_write_sequencer_if.sv
// Write-side bundle between the RTC write sequencer and its requester /
// the downstream read/write control mux.
interface rtc_write_sequencer_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ADW;
  logic       CSW;
  logic       RDW;
  logic       WRW;
  logic       SAW;
  logic       SDW;
  logic [7:0] bus_out;
  logic       busy;
  logic       done;

  modport master (
    output start, addr, data,
    input  ADW, CSW, RDW, WRW, SAW, SDW, bus_out, busy, done
  );

  modport slave (
    input  start, addr, data,
    output ADW, CSW, RDW, WRW, SAW, SDW, bus_out, busy, done
  );
endinterface

// File: rtl/rtc_write_sequencer.sv
// Two-phase (address then data) timed write cycle generator for the RTC
// multiplexed bus. Every output comes straight from a flop.
module rtc_write_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 5,
  parameter int T_HOLD  = 2,
  parameter int T_RECOV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rtc_write_sequencer_if.slave  wr
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_WR    = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_WR    = 3'd5,
    D_HOLD  = 3'd6,
    RECOV   = 3'd7
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic [7:0] addr_r, addr_s;
  logic [7:0] data_r, data_s;
  logic       adw_r, csw_r, wrw_r, saw_r, sdw_r, busy_r, done_r;
  logic       adw_s, csw_s, wrw_s, saw_s, sdw_s, busy_s, done_s;
  logic [7:0] bus_r, bus_s;

  // Dwell length (minus one) of the state being entered.
  function automatic logic [7:0] load_val(input state_t s);
    logic [7:0] v;
    case (s)
      A_SETUP, D_SETUP: v = 8'(T_SETUP - 1);
      A_WR, D_WR:       v = 8'(T_PULSE - 1);
      A_HOLD, D_HOLD:   v = 8'(T_HOLD - 1);
      RECOV:            v = 8'(T_RECOV - 1);
      default:          v = 8'd0;
    endcase
    return v;
  endfunction

  // Next state, dwell counter and operand latches.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    data_s  = data_r;
    cnt_s   = 8'd0;
    case (state_r)
      IDLE: begin
        if (wr.start) begin
          state_s = A_SETUP;
          addr_s  = wr.addr;
          data_s  = wr.data;
        end else begin
          state_s = IDLE;
        end
      end
      A_SETUP: state_s = (cnt_r == 8'd0) ? A_WR    : A_SETUP;
      A_WR:    state_s = (cnt_r == 8'd0) ? A_HOLD  : A_WR;
      A_HOLD:  state_s = (cnt_r == 8'd0) ? D_SETUP : A_HOLD;
      D_SETUP: state_s = (cnt_r == 8'd0) ? D_WR    : D_SETUP;
      D_WR:    state_s = (cnt_r == 8'd0) ? D_HOLD  : D_WR;
      D_HOLD:  state_s = (cnt_r == 8'd0) ? RECOV   : D_HOLD;
      RECOV:   state_s = (cnt_r == 8'd0) ? IDLE    : RECOV;
      default: state_s = IDLE;
    endcase
    if (state_s != state_r) begin
      cnt_s = load_val(state_s);
    end else if (cnt_r != 8'd0) begin
      cnt_s = cnt_r - 8'd1;
    end else begin
      cnt_s = 8'd0;
    end
  end

  // Output values for the upcoming state, so the strobes can be registered.
  always_comb begin
    adw_s  = 1'b1;
    csw_s  = 1'b1;
    wrw_s  = 1'b1;
    saw_s  = 1'b0;
    sdw_s  = 1'b0;
    bus_s  = 8'h00;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      A_SETUP, A_WR, A_HOLD: begin
        csw_s  = 1'b0;
        adw_s  = 1'b0;
        saw_s  = 1'b1;
        bus_s  = addr_s;
        busy_s = 1'b1;
        if (state_s == A_WR) begin
          wrw_s = 1'b0;
        end else begin
          wrw_s = 1'b1;
        end
      end
      D_SETUP, D_WR, D_HOLD: begin
        csw_s  = 1'b0;
        sdw_s  = 1'b1;
        bus_s  = data_s;
        busy_s = 1'b1;
        if (state_s == D_WR) begin
          wrw_s = 1'b0;
        end else begin
          wrw_s = 1'b1;
        end
      end
      RECOV: busy_s = 1'b1;
      IDLE: begin
        if (state_r == RECOV) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State, counter, latches and output flops; reset drops everything to idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      addr_r  <= 8'h00;
      data_r  <= 8'h00;
      adw_r   <= 1'b1;
      csw_r   <= 1'b1;
      wrw_r   <= 1'b1;
      saw_r   <= 1'b0;
      sdw_r   <= 1'b0;
      bus_r   <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      adw_r   <= adw_s;
      csw_r   <= csw_s;
      wrw_r   <= wrw_s;
      saw_r   <= saw_s;
      sdw_r   <= sdw_s;
      bus_r   <= bus_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign wr.ADW     = adw_r;
  assign wr.CSW     = csw_r;
  assign wr.RDW     = 1'b1;
  assign wr.WRW     = wrw_r;
  assign wr.SAW     = saw_r;
  assign wr.SDW     = sdw_r;
  assign wr.bus_out = bus_r;
  assign wr.busy    = busy_r;
  assign wr.done    = done_r;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench for rtc_write_sequencer: default timing instance plus a
// minimum-timing instance, checked against a cycle-index timing model.
module tb_rtc_write_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n1;
  int   n_pass   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [15:0] IDLE_V = 16'hF000;

  always #5 clk = ~clk;

  rtc_write_sequencer_if if0 ();
  rtc_write_sequencer_if if1 ();

  rtc_write_sequencer u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (if0)
  );

  rtc_write_sequencer #(
    .T_SETUP (1),
    .T_PULSE (1),
    .T_HOLD  (1),
    .T_RECOV (1)
  ) u1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .wr    (if1)
  );

  logic [15:0] act0, act1;
  assign act0 = {if0.ADW, if0.CSW, if0.RDW, if0.WRW, if0.SAW, if0.SDW, if0.bus_out, if0.busy, if0.done};
  assign act1 = {if1.ADW, if1.CSW, if1.RDW, if1.WRW, if1.SAW, if1.SDW, if1.bus_out, if1.busy, if1.done};

  // Expected outputs k cycles after the edge that accepted start (k=0 is just after E0).
  function automatic logic [15:0] exp_vec(input int k, input int ts, input int tp, input int th,
                                          input int tr, input logic [7:0] a, input logic [7:0] d);
    logic       adw = 1'b1, csw = 1'b1, wrw = 1'b1, saw = 1'b0, sdw = 1'b0;
    logic       busy = 1'b0, done = 1'b0;
    logic [7:0] bus = 8'h00;
    int         ph = ts + tp + th;
    int         j;
    if (k < ph) begin
      csw = 1'b0; adw = 1'b0; saw = 1'b1; bus = a; busy = 1'b1;
      if (k >= ts && k < ts + tp) wrw = 1'b0;
    end else if (k < 2 * ph) begin
      j = k - ph;
      csw = 1'b0; sdw = 1'b1; bus = d; busy = 1'b1;
      if (j >= ts && j < ts + tp) wrw = 1'b0;
    end else if (k < 2 * ph + tr) begin
      busy = 1'b1;
    end else if (k == 2 * ph + tr) begin
      done = 1'b1;
    end
    return {adw, csw, 1'b1, wrw, saw, sdw, bus, busy, done};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Walk one full default-timing cycle on u0, starting at the accepting edge.
  task automatic run0(input string tag, input logic [7:0] a, input logic [7:0] d,
                      input bit keep, input bit toggle);
    for (int k = 0; k <= 22; k++) begin
      @(posedge clk); #1;
      check($sformatf("%s k=%0d", tag, k), act0, exp_vec(k, 2, 5, 2, 4, a, d));
      if (!keep) begin
        if (toggle && k < 20) begin
          if0.start = k[0];
          if0.addr  = 8'hFF;
          if0.data  = 8'hFF;
        end else begin
          if0.start = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rst_n1    = 1'b0;
    if0.start = 1'($urandom);
    if0.addr  = 8'($urandom);
    if0.data  = 8'($urandom);
    if1.start = 1'($urandom);
    if1.addr  = 8'($urandom);
    if1.data  = 8'($urandom);
    #12;
    check("reset u0", act0, IDLE_V);
    check("reset u1", act1, IDLE_V);
    if0.start = 1'b0;
    if1.start = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rst_n1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle u0 c%0d", i), act0, IDLE_V);
      check($sformatf("idle u1 c%0d", i), act1, IDLE_V);
    end

    // Single write with defaults.
    if0.start = 1'b1; if0.addr = 8'h21; if0.data = 8'h5A;
    run0("single", 8'h21, 8'h5A, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("single after", act0, IDLE_V);

    // Inputs wiggling during busy must not disturb the cycle.
    if0.start = 1'b1; if0.addr = 8'h21; if0.data = 8'h5A;
    run0("stable", 8'h21, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stable after c%0d", i), act0, IDLE_V);
    end

    // Back-to-back: start held high, second cycle begins right after done.
    if0.start = 1'b1; if0.addr = 8'h3C; if0.data = 8'hC3;
    run0("b2b first", 8'h3C, 8'hC3, 1'b1, 1'b0);
    run0("b2b second", 8'h3C, 8'hC3, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b after", act0, IDLE_V);

    // Reset in the middle of the address write pulse.
    if0.start = 1'b1; if0.addr = 8'h96; if0.data = 8'h69;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst k=%0d", k), act0, exp_vec(k, 2, 5, 2, 4, 8'h96, 8'h69));
      if0.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst async", act0, IDLE_V);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst held c%0d", i), act0, IDLE_V);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("midrst released c%0d", i), act0, IDLE_V);
    end
    if0.start = 1'b1;
    run0("after rst", 8'h96, 8'h69, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("after rst idle", act0, IDLE_V);

    // Minimum timing instance, invariants every cycle.
    if1.start = 1'b1; if1.addr = 8'h0F; if1.data = 8'hF0;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("min k=%0d", k), act1, exp_vec(k, 1, 1, 1, 1, 8'h0F, 8'hF0));
      check($sformatf("min saw_sdw k=%0d", k), 16'(if1.SAW & if1.SDW), 16'h0000);
      check($sformatf("min wrw_csw k=%0d", k), 16'(~if1.WRW & if1.CSW), 16'h0000);
      if1.start = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_write_sequencer.md
# rtc_write_sequencer

Generates the timed write-cycle control signals (ADW, CSW, RDW, WRW, SDW, SAW) and the driven bus byte for the RTC's multiplexed address/data bus. It sits directly upstream of the read/write control-signal mux and feeds that mux's write-side inputs. A write is two phases: the register address is strobed in, then the data byte. Phase lengths are parameterised in clock cycles.

## Interface
Parameters:
- T_SETUP, default 2: cycles that AD/CS/bus are stable before WR falls. Range 1..255.
- T_PULSE, default 5: cycles that WR is held low. Range 1..255.
- T_HOLD, default 2: cycles that AD/CS/bus are held after WR rises. Range 1..255.
- T_RECOV, default 4: idle cycles after the data phase before `done`. Range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a write cycle. Sampled only in IDLE.
- addr  in  8  RTC register address. Latched when start is accepted.
- data  in  8  data byte. Latched when start is accepted.
- ADW  out  1  address/data strobe, active-low (0 = address phase).
- CSW  out  1  chip select, active-low.
- RDW  out  1  read strobe. Constant 1 in this block.
- WRW  out  1  write strobe, active-low.
- SAW  out  1  drive the address onto the bus, active-high.
- SDW  out  1  drive the data onto the bus, active-high.
- bus_out  out  8  byte presented to the bus driver.
- busy  out  1  high while a cycle is in progress.
- done  out  1  one-cycle pulse marking cycle completion.

## Operation
- Idle/reset values: ADW=1, CSW=1, RDW=1, WRW=1, SAW=0, SDW=0, bus_out=0, busy=0, done=0. The latched addr/data registers reset to 0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from the inputs.
- The FSM runs IDLE → A_SETUP → A_WR → A_HOLD → D_SETUP → D_WR → D_HOLD → RECOV → IDLE.
- Each non-IDLE state lasts exactly its parameter in cycles: SETUP=T_SETUP, WR=T_PULSE, HOLD=T_HOLD, RECOV=T_RECOV.
- An 8-bit down-counter is loaded with (param−1) on state entry. The FSM advances when the counter is 0.
- Output values by state:
  - A_* states: CSW=0, ADW=0, SAW=1, SDW=0, bus_out=addr_latched. WRW=0 only in A_WR.
  - D_* states: CSW=0, ADW=1, SAW=0, SDW=1, bus_out=data_latched. WRW=0 only in D_WR.
  - RECOV: all strobes at idle values, bus_out=0, busy=1.
- Invariants:
  - SAW and SDW are never high together.
  - WRW low implies CSW low.
  - ADW changes only while WRW=1.
- busy=1 in every non-IDLE state.
- done=1 for exactly the first IDLE cycle after RECOV.
- start is ignored while busy. addr/data changes after acceptance have no effect.
- start high in the done cycle is accepted, so cycles run back-to-back.
- An rst_n assertion at any point, including mid-WR pulse:
  - forces all outputs to idle values immediately (asynchronously);
  - no done pulse is generated;
  - a subsequent start is needed to begin a new cycle.

## Timing
- The edge that samples start=1 in IDLE is E0. A_SETUP outputs are valid after E0.
- Total busy length = 2·(T_SETUP+T_PULSE+T_HOLD)+T_RECOV cycles. done is high in the next cycle.
- With defaults:
  - busy for 22 cycles (after E0 through E21);
  - WRW low after E2..E6 (address) and after E11..E15 (data);
  - ADW rises after E9;
  - done is high after E22.
- WRW low width = T_PULSE cycles exactly. Address-to-data gap (WRW high between pulses) = T_HOLD+T_SETUP cycles.
- Worst-case start-to-done latency = total + 1 cycle.

## Test plan
- Reset: rst_n=0 with random inputs → all outputs at idle values. Release, hold start=0 for 10 cycles → outputs unchanged.
- Single write, defaults, addr=0x21, data=0x5A:
  - bus_out=0x21 with SAW=1 and ADW=0 for 9 cycles;
  - then 0x5A with SDW=1 and ADW=1 for 9 cycles;
  - WRW low for 5 cycles after E2 and after E11;
  - done only after E22.
- Input stability: toggle start and change addr/data to 0xFF during busy → no restart, latched bytes 0x21/0x5A still driven, exactly one done.
- Back-to-back: start held high continuously → second cycle's A_SETUP begins immediately after the done cycle. Two done pulses 23 cycles apart.
- Reset mid-op: rst_n low during A_WR (after E4) → WRW, CSW, ADW go to 1 and SAW to 0 without waiting for a clock edge, no done. A new start then runs a full 22-cycle sequence.
- Parameters T_SETUP=1, T_PULSE=1, T_HOLD=1, T_RECOV=1 → busy 7 cycles, each WRW pulse 1 cycle wide. Check the SAW/SDW-exclusive and WRW⇒CSW invariants hold every cycle.
